conv_window_gen: RTL and testbench

//  Producer side of the 5x5 conv MAC: accepts one input feature map as a row-major pixel stream.

---
 rtl/conv_window_gen_pkg.sv | 23 ++
 rtl/conv_line_buffer.sv | 34 +++
 rtl/conv_window_gen.sv | 236 +++++++++++++++++++++++
 tb/tb_conv_window_gen.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_gen_pkg
//  Description : Shared FSM encoding and MAC latency for the 5x5 conv window
//                generator and its MAC wrapper.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_window_gen_pkg;

    // One-hot frame-sequencing states
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_RUN   = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_DONE  = 4'b1000
    } state_e;

    // Cycles from a window on the MAC inputs to a valid MAC output
    // (1 multiply stage + 5 adder-tree stages)
    localparam int C_CALC_LATENCY = 6;

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_line_buffer
//  Description : One feature-map row of storage. Single-port RAM, indexed by
//                column, read-before-write: the read port returns the value
//                stored before the write that happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_line_buffer #(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 32,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Combinational read sees the old contents during the writing cycle
    assign rd_data_o = mem_q[addr_i];

    // Contents are never reset; rows are always written before being read
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_gen
//  Description : Turns a row-major pixel stream into flattened 5x5 windows for
//                the conv MAC, plus a res_valid strobe aligned with the MAC
//                output. Element k = r*FILTER_WIDTH + c, r=0 oldest row,
//                c=0 leftmost column.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter  int DATA_WIDTH    = 16,
    parameter  int FILTER_WIDTH  = 5,
    parameter  int FILTER_HEIGTH = 5,
    parameter  int INPUT_WIDTH   = 32,
    parameter  int INPUT_HEIGTH  = 32,
    parameter  int CALC_LATENCY  = C_CALC_LATENCY,
    localparam int OUTPUT_WIDTH  = INPUT_WIDTH - FILTER_WIDTH + 1,
    localparam int OUTPUT_HEIGTH = INPUT_HEIGTH - FILTER_HEIGTH + 1,
    localparam int WIN_BITS      = FILTER_WIDTH * FILTER_HEIGTH * DATA_WIDTH,
    localparam int ORW           = $clog2(OUTPUT_HEIGTH),
    localparam int OCW           = $clog2(OUTPUT_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  pix_valid_i,
    input  logic [DATA_WIDTH-1:0] pix_data_i,
    output logic                  win_valid_o,
    output logic [WIN_BITS-1:0]   win_data_o,
    output logic [ORW-1:0]        win_row_o,
    output logic [OCW-1:0]        win_col_o,
    output logic                  res_valid_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int CW  = $clog2(INPUT_WIDTH);
    localparam int RW  = $clog2(INPUT_HEIGTH);
    localparam int NLB = FILTER_HEIGTH - 1;
    localparam int DCW = $clog2(CALC_LATENCY + 1);

    localparam logic [CW-1:0]  C_COL_LAST      = CW'(INPUT_WIDTH - 1);
    localparam logic [RW-1:0]  C_ROW_LAST      = RW'(INPUT_HEIGTH - 1);
    localparam logic [CW-1:0]  C_COL_FIRST_WIN = CW'(FILTER_WIDTH - 1);
    localparam logic [RW-1:0]  C_ROW_FIRST_WIN = RW'(FILTER_HEIGTH - 1);
    localparam logic [DCW-1:0] C_DRAIN_LAST    = DCW'(CALC_LATENCY);

    state_e                state_q, state_d;
    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic [DCW-1:0]        drain_q;

    logic                  accept;
    logic                  last_pix;
    logic                  emit;

    logic [DATA_WIDTH-1:0] lb_rd     [NLB];
    logic [DATA_WIDTH-1:0] lb_wr     [NLB];
    logic [DATA_WIDTH-1:0] col_stack [FILTER_HEIGTH];

    logic [DATA_WIDTH-1:0] win_q     [FILTER_HEIGTH][FILTER_WIDTH];
    logic [DATA_WIDTH-1:0] win_d     [FILTER_HEIGTH][FILTER_WIDTH];
    logic [WIN_BITS-1:0]   win_flat_d;

    logic                  win_valid_q;
    logic [WIN_BITS-1:0]   win_data_q;
    logic [ORW-1:0]        win_row_q;
    logic [OCW-1:0]        win_col_q;
    logic [CALC_LATENCY-1:0] res_pipe_q;

    assign accept   = pix_valid_i && (state_q == ST_RUN);
    assign last_pix = (col_q == C_COL_LAST) && (row_q == C_ROW_LAST);
    assign emit     = accept && (row_q >= C_ROW_FIRST_WIN) && (col_q >= C_COL_FIRST_WIN);

    // Line-buffer chain: buffer 0 holds the oldest row. On every accept each
    // buffer takes the column read from its younger neighbour, and the newest
    // buffer takes the incoming pixel.
    generate
        for (genvar i = 0; i < NLB; i++) begin : g_line_buf
            if (i == NLB - 1) begin : g_newest
                assign lb_wr[i] = pix_data_i;
            end else begin : g_older
                assign lb_wr[i] = lb_rd[i + 1];
            end

            conv_line_buffer #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (INPUT_WIDTH)
            ) u_line_buf (
                .clk        (clk),
                .we_i       (accept),
                .addr_i     (col_q),
                .wr_data_i  (lb_wr[i]),
                .rd_data_o  (lb_rd[i])
            );

            assign col_stack[i] = lb_rd[i];
        end
    endgenerate

    assign col_stack[FILTER_HEIGTH-1] = pix_data_i;

    // Next window: shift every row one column left, new column enters on the right
    always_comb begin
        win_d = win_q;
        for (int r = 0; r < FILTER_HEIGTH; r++) begin
            for (int c = 0; c < FILTER_WIDTH - 1; c++) begin
                win_d[r][c] = win_q[r][c + 1];
            end
            win_d[r][FILTER_WIDTH-1] = col_stack[r];
        end
    end

    // Flatten the next window into the MAC input ordering
    always_comb begin
        win_flat_d = '0;
        for (int r = 0; r < FILTER_HEIGTH; r++) begin
            for (int c = 0; c < FILTER_WIDTH; c++) begin
                win_flat_d[(r*FILTER_WIDTH + c)*DATA_WIDTH +: DATA_WIDTH] = win_d[r][c];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and status outputs; DRAIN lasts until the last
    // res_valid has left the pipe
    always_comb begin
        state_d      = state_q;
        busy_o       = 1'b0;
        frame_done_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_o = 1'b1;
                if (accept && last_pix) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
                if (drain_q == C_DRAIN_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done_o = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pixel position counters and drain cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && start_i) begin
                col_q <= '0;
                row_q <= '0;
            end else if (accept) begin
                if (col_q == C_COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == C_ROW_LAST) ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end

            if (state_q == ST_DRAIN) begin
                drain_q <= drain_q + DCW'(1);
            end else begin
                drain_q <= '0;
            end
        end
    end

    // Window shift register advances only on accepted pixels
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < FILTER_HEIGTH; r++) begin
                for (int c = 0; c < FILTER_WIDTH; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            win_q <= win_d;
        end
    end

    // Output window register, held between emitted windows; res_valid pipe
    // free-runs to track the MAC
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            res_pipe_q  <= '0;
        end else begin
            win_valid_q <= emit;
            if (emit) begin
                win_data_q <= win_flat_d;
                win_row_q  <= ORW'(row_q - C_ROW_FIRST_WIN);
                win_col_q  <= OCW'(col_q - C_COL_FIRST_WIN);
            end
            res_pipe_q <= {res_pipe_q[CALC_LATENCY-2:0], win_valid_q};
        end
    end

    assign win_valid_o = win_valid_q;
    assign win_data_o  = win_data_q;
    assign win_row_o   = win_row_q;
    assign win_col_o   = win_col_q;
    assign res_valid_o = res_pipe_q[CALC_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_gen
//  Description : Self-checking bench for conv_window_gen. Windows are predicted
//                from a stored image and the list of cycles in which pixels
//                were accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_gen;

    localparam int DW   = 16;
    localparam int FW   = 5;
    localparam int FH   = 5;
    localparam int IW   = 32;
    localparam int IH   = 32;
    localparam int LAT  = 6;
    localparam int OW   = IW - FW + 1;
    localparam int OH   = IH - FH + 1;
    localparam int WB   = FW * FH * DW;
    localparam int NWIN = OW * OH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          pix_valid_i = 1'b0;
    logic [DW-1:0] pix_data_i = '0;
    logic          win_valid_o;
    logic [WB-1:0] win_data_o;
    logic [4:0]    win_row_o;
    logic [4:0]    win_col_o;
    logic          res_valid_o;
    logic          busy_o;
    logic          frame_done_o;

    conv_window_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .pix_valid_i  (pix_valid_i),
        .pix_data_i   (pix_data_i),
        .win_valid_o  (win_valid_o),
        .win_data_o   (win_data_o),
        .win_row_o    (win_row_o),
        .win_col_o    (win_col_o),
        .res_valid_o  (res_valid_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [WB-1:0] data;
        logic [4:0]    row;
        logic [4:0]    col;
    } win_rec_t;

    win_rec_t      wins[$];
    int            res_cycs[$];
    int            done_cycs[$];
    int            acc_cycs[$];
    bit            busy_at[int];
    logic [DW-1:0] img [IH][IW];

    int checks = 0;
    int fails  = 0;

    // Record observed outputs mid-cycle
    always @(negedge clk) begin
        if (win_valid_o) wins.push_back('{cyc, win_data_o, win_row_o, win_col_o});
        if (res_valid_o) res_cycs.push_back(cyc);
        if (frame_done_o) done_cycs.push_back(cyc);
        busy_at[cyc] = busy_o;
    end

    task automatic clear_obs();
        wins.delete();
        res_cycs.delete();
        done_cycs.delete();
        acc_cycs.delete();
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = DW'(r * IW + c);
    endtask

    task automatic fill_random();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = DW'($urandom);
    endtask

    // Drive one frame; idle_pixels are offered before start and must be ignored
    task automatic run_frame(input int duty, input int stray_start_at, input int idle_pixels);
        int idx;
        int guard;
        bit stray_done;
        clear_obs();
        for (int i = 0; i < idle_pixels; i++) begin
            pix_valid_i = 1'b1;
            pix_data_i  = DW'($urandom);
            @(posedge clk); #1;
        end
        pix_valid_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        idx = 0;
        guard = 0;
        stray_done = 1'b0;
        while (idx < IW * IH && guard < 20000) begin
            start_i = 1'b0;
            if ($urandom_range(99) < duty) begin
                if (!stray_done && idx == stray_start_at) begin
                    start_i = 1'b1;
                    stray_done = 1'b1;
                end
                pix_valid_i = 1'b1;
                pix_data_i  = img[idx / IW][idx % IW];
                acc_cycs.push_back(cyc);
                idx++;
            end else begin
                pix_valid_i = 1'b0;
                pix_data_i  = DW'($urandom);
            end
            @(posedge clk); #1;
            guard++;
        end
        start_i = 1'b0;
        pix_valid_i = 1'b0;
        checks++;
        if (idx != IW * IH) begin
            fails++;
            $display("FAIL frame_feed: fed %0d pixels, required %0d", idx, IW * IH);
        end
        repeat (LAT + 6) @(posedge clk);
        #1;
    endtask

    // Compare the recorded frame against windows predicted from img
    task automatic test_frame_outputs(input string name);
        int n;
        int last_acc;
        int orow;
        int ocol;
        int exp_cyc;
        logic [WB-1:0] exp;
        checks++;
        if (wins.size() != NWIN) begin
            fails++;
            $display("FAIL %s win_count: got %0d, required %0d", name, wins.size(), NWIN);
        end
        n = (wins.size() < NWIN) ? wins.size() : NWIN;
        for (int i = 0; i < n; i++) begin
            orow = i / OW;
            ocol = i % OW;
            for (int r = 0; r < FH; r++)
                for (int c = 0; c < FW; c++)
                    exp[(r*FW + c)*DW +: DW] = img[orow + r][ocol + c];
            exp_cyc = acc_cycs[(orow + FH - 1) * IW + ocol + FW - 1] + 1;
            checks++;
            if (wins[i].data !== exp || wins[i].row != orow || wins[i].col != ocol
                || wins[i].cyc != exp_cyc) begin
                fails++;
                $display("FAIL %s win[%0d]: got row=%0d col=%0d cyc=%0d data=%h, required row=%0d col=%0d cyc=%0d data=%h",
                         name, i, wins[i].row, wins[i].col, wins[i].cyc, wins[i].data,
                         orow, ocol, exp_cyc, exp);
            end
        end
        checks++;
        if (res_cycs.size() != wins.size()) begin
            fails++;
            $display("FAIL %s res_count: got %0d, required %0d", name, res_cycs.size(), wins.size());
        end
        n = (res_cycs.size() < wins.size()) ? res_cycs.size() : wins.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (res_cycs[i] != wins[i].cyc + LAT) begin
                fails++;
                $display("FAIL %s res_valid[%0d]: got cycle %0d, required %0d",
                         name, i, res_cycs[i], wins[i].cyc + LAT);
            end
        end
        last_acc = (acc_cycs.size() > 0) ? acc_cycs[acc_cycs.size() - 1] : 0;
        checks++;
        if (done_cycs.size() != 1) begin
            fails++;
            $display("FAIL %s frame_done_count: got %0d, required 1", name, done_cycs.size());
        end else begin
            checks++;
            if (done_cycs[0] != last_acc + LAT + 2) begin
                fails++;
                $display("FAIL %s frame_done_cycle: got %0d, required %0d",
                         name, done_cycs[0], last_acc + LAT + 2);
            end
        end
        checks++;
        if (busy_at[last_acc + LAT + 3] !== 1'b0 || busy_at[last_acc] !== 1'b1) begin
            fails++;
            $display("FAIL %s busy: got run=%0b after=%0b, required run=1 after=0",
                     name, busy_at[last_acc], busy_at[last_acc + LAT + 3]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start_i = 1'b1;              // coincides with reset, must be lost
        pix_valid_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start_i = 1'b0;
        checks++; if (win_valid_o !== 1'b0) begin fails++; $display("FAIL reset win_valid: got %0b, required 0", win_valid_o); end
        checks++; if (win_data_o !== '0)    begin fails++; $display("FAIL reset win_data: got %h, required 0", win_data_o); end
        checks++; if (win_row_o !== 5'd0)   begin fails++; $display("FAIL reset win_row: got %0d, required 0", win_row_o); end
        checks++; if (win_col_o !== 5'd0)   begin fails++; $display("FAIL reset win_col: got %0d, required 0", win_col_o); end
        checks++; if (res_valid_o !== 1'b0) begin fails++; $display("FAIL reset res_valid: got %0b, required 0", res_valid_o); end
        checks++; if (frame_done_o !== 1'b0) begin fails++; $display("FAIL reset frame_done: got %0b, required 0", frame_done_o); end
        clear_obs();
        repeat (8) @(posedge clk);
        #1;
        pix_valid_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || wins.size() != 0) begin
            fails++;
            $display("FAIL reset start_with_rst: got busy=%0b windows=%0d, required busy=0 windows=0",
                     busy_o, wins.size());
        end
    endtask

    task automatic test_ramp();
        logic [WB-1:0] d;
        fill_ramp();
        run_frame(100, -1, 0);
        checks++;
        if (wins.size() == 0) begin
            fails++;
            $display("FAIL ramp_first_window: got no window, required one");
        end else begin
            d = wins[0].data;
            checks++;
            if (wins[0].cyc != acc_cycs[132] + 1 || wins[0].row != 0 || wins[0].col != 0) begin
                fails++;
                $display("FAIL ramp_first_pos: got cyc=%0d row=%0d col=%0d, required cyc=%0d row=0 col=0",
                         wins[0].cyc, wins[0].row, wins[0].col, acc_cycs[132] + 1);
            end
            checks++;
            if (d[0*DW +: DW] !== 16'd0 || d[4*DW +: DW] !== 16'd4
                || d[20*DW +: DW] !== 16'd128 || d[24*DW +: DW] !== 16'd132) begin
                fails++;
                $display("FAIL ramp_first_data: got k0=%0d k4=%0d k20=%0d k24=%0d, required 0 4 128 132",
                         d[0*DW +: DW], d[4*DW +: DW], d[20*DW +: DW], d[24*DW +: DW]);
            end
            d = wins[wins.size() - 1].data;
            checks++;
            if (wins[wins.size() - 1].row != 27 || wins[wins.size() - 1].col != 27
                || d[24*DW +: DW] !== 16'd1023) begin
                fails++;
                $display("FAIL ramp_last: got row=%0d col=%0d k24=%0d, required 27 27 1023",
                         wins[wins.size() - 1].row, wins[wins.size() - 1].col, d[24*DW +: DW]);
            end
        end
        test_frame_outputs("ramp");
    endtask

    task automatic test_random_gaps();
        fill_ramp();
        run_frame(50, -1, 0);
        test_frame_outputs("gaps");
    endtask

    task automatic test_start_ignored();
        fill_random();
        run_frame(70, 200, 40);
        test_frame_outputs("stray_start");
    endtask

    task automatic test_rst_mid_frame();
        clear_obs();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 500; i++) begin
            pix_valid_i = 1'b1;
            pix_data_i  = DW'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (win_valid_o !== 1'b0 || win_data_o !== '0 || win_row_o !== 5'd0 || win_col_o !== 5'd0
            || res_valid_o !== 1'b0 || busy_o !== 1'b0 || frame_done_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid outputs: got wv=%0b row=%0d col=%0d rv=%0b busy=%0b fd=%0b data_nz=%0b, required all 0",
                     win_valid_o, win_row_o, win_col_o, res_valid_o, busy_o, frame_done_o, |win_data_o);
        end
        clear_obs();
        repeat (LAT + 8) @(posedge clk);
        #1;
        pix_valid_i = 1'b0;
        checks++;
        if (done_cycs.size() != 0 || res_cycs.size() != 0 || wins.size() != 0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid aftermath: got frame_done=%0d res_valid=%0d windows=%0d busy=%0b, required 0 0 0 0",
                     done_cycs.size(), res_cycs.size(), wins.size(), busy_o);
        end
        fill_ramp();
        run_frame(100, -1, 0);
        test_frame_outputs("after_rst");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_random_gaps();
        test_start_ignored();
        test_rst_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
